sonar_fd: RTL and testbench

Datapath of the sonar controller. It drives an HC-SR04-style ultrasonic sensor: trigger pulse, echo-width measurement and conversion to centimetres in BCD. It also produces the servo PWM for one of 8 positions, transmits ASCII bytes over a UART line, and provides a 2 s tick timer. Every control input comes from the sonar control unit (sonar_uc); this block holds no sequencing decisions beyond its local handshakes.

---
 rtl/sonar_pkg.sv | 46 ++++
 rtl/sonar_uart_tx.sv | 74 +++++++
 rtl/sonar_fd.sv | 204 ++++++++++++++++++++
 tb/tb_sonar_fd.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared constants for the sonar datapath: ASCII codes, angle ROM, FSM encodings.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package sonar_pkg;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_HASH  = 8'h23;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Servo angle for each position as three ASCII digits; entry k is 20*(k+1) degrees.
  localparam logic [23:0] ANGLE_ROM [8] = '{
    "020", "040", "060", "080", "100", "120", "140", "160"
  };

  // Measurement FSM encodings.
  localparam logic [2:0] MS_IDLE = 3'd0;
  localparam logic [2:0] MS_TRIG = 3'd1;
  localparam logic [2:0] MS_WAIT = 3'd2;
  localparam logic [2:0] MS_MEAS = 3'd3;
  localparam logic [2:0] MS_DONE = 3'd4;

  // UART transmitter FSM encodings.
  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_BUSY = 1'b1;

  // Three-digit BCD increment that sticks at 999 instead of rolling over.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    if (d != 12'h999) begin
      if (d[3:0] != 4'd9) begin
        r[3:0] = d[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (d[7:4] != 4'd9) begin
          r[7:4] = d[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = d[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sonar_uart_tx.sv
// 8N1 UART transmitter, LSB first, BAUD_DIV cycles per bit.
// Latency: line drops to the start bit one cycle after start_i; done_o rises 10*BAUD_DIV cycles after that edge.
// Backpressure: start_i is only sampled while idle; requests during a frame are dropped.
module sonar_uart_tx
  import sonar_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);
  localparam int BW = $clog2(BAUD_DIV + 1);

  logic [0:0]    state_q, state_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          done_q, done_d;

  // Frame sequencing: load {stop, data, start} and shift it out one bit per baud period.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    done_d  = done_q;
    if (state_q == TX_IDLE) begin
      if (start_i) begin
        sh_d    = {1'b1, data_i, 1'b0};
        bit_d   = 4'd0;
        baud_d  = '0;
        done_d  = 1'b0;
        state_d = TX_BUSY;
      end
    end else if (baud_q == BW'(BAUD_DIV - 1)) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        state_d = TX_IDLE;
        done_d  = 1'b1;
      end else begin
        // Shift in ones so the line rests high when the frame is over.
        sh_d  = {1'b1, sh_q[9:1]};
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + BW'(1);
    end
  end

  // State registers; the shift register resets to all ones so the line idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      sh_q    <= '1;
      bit_q   <= 4'd0;
      baud_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      done_q  <= done_d;
    end
  end

  assign tx_o   = sh_q[0];
  assign done_o = done_q;

endmodule

// File: rtl/sonar_fd.sv
// Sonar datapath: echo ranging to BCD centimetres, servo PWM, UART byte mux/TX, 2 s tick timer.
// Latency: sensor_pronto 2 cycles after the synchronised echo falls; UART byte 10*BAUD_DIV cycles.
// Backpressure: none; medicao/transmissao are levels honoured only while the matching engine is idle.
module sonar_fd
  import sonar_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TRIG_CYCLES = 500,
  parameter int CM_CYCLES   = 2941,
  parameter int BAUD_DIV    = 434,
  parameter int PWM_PERIOD  = 1_000_000,
  parameter int PWM_MIN     = 50_000,
  parameter int PWM_STEP    = 7_143,
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       echo,
  input  logic       medicao,
  input  logic       transmissao,
  input  logic       limpa_tick_2s,
  input  logic       conta_tick_2s,
  input  logic [2:0] sel_rom,
  input  logic [2:0] sel_transmissao,
  input  logic [2:0] sel_posicao,
  output logic       tick_2s,
  output logic       trigger,
  output logic       pwm,
  output logic       saida_serial,
  output logic       serial_pronto,
  output logic       sensor_pronto,
  output logic [3:0] contador
);
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int CW = $clog2(CM_CYCLES + 1);
  localparam int PW = $clog2(PWM_PERIOD + 1);
  localparam int KW = $clog2(TICK_CYCLES + 1);

  // CLK_HZ only documents the timing the other parameters were derived from.
  if (CLK_HZ <= 0) begin : g_clk_hz_check
    $error("CLK_HZ must be positive");
  end

  logic          echo_m_q, echo_s_q, echo_p_q;
  logic          echo_rise;
  logic [2:0]    ms_q, ms_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [CW-1:0] cm_cnt_q, cm_cnt_d;
  logic [11:0]   dist_q, dist_d;
  logic          spr_q, spr_d;
  logic [PW-1:0] pwm_cnt_q;
  logic [31:0]   pwm_w_q, pwm_w_cur;
  logic          pwm_q;
  logic [KW-1:0] tick_cnt_q;
  logic          tick_q;
  logic [3:0]    cont_q;
  logic [23:0]   rom_word;
  logic [7:0]    tx_byte;

  // Two-flop synchroniser for the asynchronous echo, plus a delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m_q <= 1'b0;
      echo_s_q <= 1'b0;
      echo_p_q <= 1'b0;
    end else begin
      echo_m_q <= echo;
      echo_s_q <= echo_m_q;
      echo_p_q <= echo_s_q;
    end
  end

  assign echo_rise = echo_s_q & ~echo_p_q;

  // Measurement FSM. MEASURE counts every cycle up to and including the one that sees echo low,
  // which together with the rise cycle spent in WAIT makes the count equal the echo width.
  always_comb begin
    ms_d       = ms_q;
    trig_cnt_d = trig_cnt_q;
    cm_cnt_d   = cm_cnt_q;
    dist_d     = dist_q;
    spr_d      = spr_q;
    case (ms_q)
      MS_IDLE: if (medicao) begin
        spr_d      = 1'b0;
        trig_cnt_d = '0;
        ms_d       = MS_TRIG;
      end
      MS_TRIG: if (trig_cnt_q == TW'(TRIG_CYCLES - 1)) begin
        ms_d = MS_WAIT;
      end else begin
        trig_cnt_d = trig_cnt_q + TW'(1);
      end
      MS_WAIT: if (echo_rise) begin
        cm_cnt_d = '0;
        dist_d   = 12'h000;
        ms_d     = MS_MEAS;
      end
      MS_MEAS: begin
        if (cm_cnt_q == CW'(CM_CYCLES - 1)) begin
          cm_cnt_d = '0;
          dist_d   = bcd_inc_sat(dist_q);
        end else begin
          cm_cnt_d = cm_cnt_q + CW'(1);
        end
        if (!echo_s_q) ms_d = MS_DONE;
      end
      MS_DONE: begin
        spr_d = 1'b1;
        ms_d  = MS_IDLE;
      end
      default: ms_d = MS_IDLE;
    endcase
  end

  // Measurement state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_q       <= MS_IDLE;
      trig_cnt_q <= '0;
      cm_cnt_q   <= '0;
      dist_q     <= 12'h000;
      spr_q      <= 1'b0;
    end else begin
      ms_q       <= ms_d;
      trig_cnt_q <= trig_cnt_d;
      cm_cnt_q   <= cm_cnt_d;
      dist_q     <= dist_d;
      spr_q      <= spr_d;
    end
  end

  // Pulse width is re-evaluated only at the period start so a position change never chops a pulse.
  assign pwm_w_cur = (pwm_cnt_q == '0)
                   ? (32'(PWM_MIN) + 32'(sel_posicao) * 32'(PWM_STEP))
                   : pwm_w_q;

  // Free-running PWM period counter and registered output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q <= '0;
      pwm_w_q   <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + PW'(1);
      pwm_w_q   <= pwm_w_cur;
      pwm_q     <= (32'(pwm_cnt_q) < pwm_w_cur);
    end
  end

  // Tick timer: clear wins over count; each wrap pulses tick_2s and bumps contador.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      cont_q     <= 4'd0;
    end else if (limpa_tick_2s) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      cont_q     <= 4'd0;
    end else if (conta_tick_2s && (tick_cnt_q == KW'(TICK_CYCLES - 1))) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
      cont_q     <= cont_q + 4'd1;
    end else begin
      tick_cnt_q <= conta_tick_2s ? tick_cnt_q + KW'(1) : tick_cnt_q;
      tick_q     <= 1'b0;
    end
  end

  // Byte to transmit: angle digits, separator, distance digits, terminator.
  always_comb begin
    rom_word = ANGLE_ROM[sel_rom];
    tx_byte  = ASCII_HASH;
    case (sel_transmissao)
      3'd0: tx_byte = rom_word[23:16];
      3'd1: tx_byte = rom_word[15:8];
      3'd2: tx_byte = rom_word[7:0];
      3'd3: tx_byte = ASCII_COMMA;
      3'd4: tx_byte = ASCII_ZERO + {4'd0, dist_q[11:8]};
      3'd5: tx_byte = ASCII_ZERO + {4'd0, dist_q[7:4]};
      3'd6: tx_byte = ASCII_ZERO + {4'd0, dist_q[3:0]};
      default: tx_byte = ASCII_HASH;
    endcase
  end

  sonar_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk_i   (clock),
    .rst_ni  (reset),
    .start_i (transmissao),
    .data_i  (tx_byte),
    .tx_o    (saida_serial),
    .done_o  (serial_pronto)
  );

  assign trigger       = (ms_q == MS_TRIG);
  assign sensor_pronto = spr_q;
  assign pwm           = pwm_q;
  assign tick_2s       = tick_q;
  assign contador      = cont_q;

endmodule

// File: tb/tb_sonar_fd.sv
// Randomised bench for sonar_fd with a UART scoreboard and arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sonar_fd;
  localparam int TRIG = 20;
  localparam int CM   = 10;
  localparam int BAUD = 4;
  localparam int PER  = 200;
  localparam int PMIN = 20;
  localparam int PSTP = 7;
  localparam int TICK = 8;

  logic       clock;
  logic       reset;
  logic       echo, medicao, transmissao, limpa_tick_2s, conta_tick_2s;
  logic [2:0] sel_rom, sel_transmissao, sel_posicao;
  logic       tick_2s, trigger, pwm, saida_serial, serial_pronto, sensor_pronto;
  logic [3:0] contador;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_seen = 0;
  int model_dist = 0;
  logic [7:0] exp_q[$];

  sonar_fd #(
    .CLK_HZ(50_000_000), .TRIG_CYCLES(TRIG), .CM_CYCLES(CM), .BAUD_DIV(BAUD),
    .PWM_PERIOD(PER), .PWM_MIN(PMIN), .PWM_STEP(PSTP), .TICK_CYCLES(TICK)
  ) dut (
    .clock(clock), .reset(reset), .echo(echo), .medicao(medicao),
    .transmissao(transmissao), .limpa_tick_2s(limpa_tick_2s),
    .conta_tick_2s(conta_tick_2s), .sel_rom(sel_rom),
    .sel_transmissao(sel_transmissao), .sel_posicao(sel_posicao),
    .tick_2s(tick_2s), .trigger(trigger), .pwm(pwm),
    .saida_serial(saida_serial), .serial_pronto(serial_pronto),
    .sensor_pronto(sensor_pronto), .contador(contador)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (reset && tick_2s) tick_seen <= tick_seen + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ascii_digit(input int v, input int p);
    return 8'(8'h30 + (v / p) % 10);
  endfunction

  // What the line should carry for a given byte select, from the angle/distance in degrees/cm.
  function automatic logic [7:0] model_byte(input int s, input int k, input int d);
    int a;
    a = 20 * (k + 1);
    case (s)
      0: return ascii_digit(a, 100);
      1: return ascii_digit(a, 10);
      2: return ascii_digit(a, 1);
      3: return 8'h2C;
      4: return ascii_digit(d, 100);
      5: return ascii_digit(d, 10);
      6: return ascii_digit(d, 1);
      default: return 8'h23;
    endcase
  endfunction

  // UART monitor: decodes every frame on the line and compares it with the scoreboard head.
  initial begin : uart_mon
    logic [7:0] rx;
    logic [7:0] want;
    forever begin
      @(negedge clock);
      if (reset && saida_serial == 1'b0) begin
        repeat (BAUD / 2) @(negedge clock);
        check("start_bit", {31'd0, saida_serial}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clock);
          rx[i] = saida_serial;
        end
        repeat (BAUD) @(negedge clock);
        check("stop_bit", {31'd0, saida_serial}, 32'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL uart_extra: got 0x%0h expected no frame", rx);
        end else begin
          want = exp_q.pop_front();
          check("uart_byte", {24'd0, rx}, {24'd0, want});
        end
      end
    end
  end

  task automatic send(input int st, input int sr, input bit poke);
    int n;
    sel_transmissao = 3'(st);
    sel_rom         = 3'(sr);
    exp_q.push_back(model_byte(st, sr, model_dist));
    transmissao = 1'b1;
    @(posedge clock); #1;
    transmissao = 1'b0;
    check("pronto_clr", {31'd0, serial_pronto}, 32'd0);
    n = 0;
    while (!serial_pronto && n < 20 * BAUD) begin
      @(posedge clock); #1;
      n++;
      if (poke && n == 8) begin
        transmissao     = 1'b1;
        sel_transmissao = 3'd7;
      end
      if (poke && n == 9) transmissao = 1'b0;
    end
    check("tx_time", n, 10 * BAUD);
    repeat (3) @(posedge clock); #1;
    check("pronto_hold", {31'd0, serial_pronto}, 32'd1);
  endtask

  task automatic measure(input int width);
    int n;
    medicao = 1'b1;
    @(posedge clock); #1;
    medicao = 1'b0;
    check("sensor_pronto_clr", {31'd0, sensor_pronto}, 32'd0);
    n = 0;
    while (trigger && n < 4 * TRIG) begin
      @(posedge clock); #1;
      n++;
    end
    check("trigger_width", n, TRIG);
    repeat (3) @(posedge clock); #1;
    echo = 1'b1;
    repeat (width) @(posedge clock);
    #1 echo = 1'b0;
    n = 0;
    while (!sensor_pronto && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("sensor_pronto", {31'd0, sensor_pronto}, 32'd1);
    model_dist = (width / CM > 999) ? 999 : width / CM;
    for (int s = 4; s <= 6; s++) send(s, 0, 1'b0);
    check("sensor_pronto_hold", {31'd0, sensor_pronto}, 32'd1);
  endtask

  task automatic wait_rise(output bit ok, output int at);
    int n;
    n = 0;
    while (pwm && n < 4 * PER) begin @(negedge clock); n++; end
    while (!pwm && n < 4 * PER) begin @(negedge clock); n++; end
    ok = pwm;
    at = cyc;
  endtask

  task automatic enable_cycles(input int c);
    conta_tick_2s = 1'b1;
    repeat (c) @(posedge clock);
    #1 conta_tick_2s = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int widths[$];
    int base, left, burst, prev, nxt, w, t0, t1;
    bit ok;
    reset = 1'b0; echo = 1'b0; medicao = 1'b0; transmissao = 1'b0;
    limpa_tick_2s = 1'b0; conta_tick_2s = 1'b0;
    sel_rom = 3'd0; sel_transmissao = 3'd0; sel_posicao = 3'd0;
    repeat (4) @(negedge clock);
    check("rst_pwm", {31'd0, pwm}, 32'd0);
    check("rst_serial_in", {31'd0, saida_serial}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;
    check("rst_serial", {31'd0, saida_serial}, 32'd1);
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_contador", {28'd0, contador}, 32'd0);
    check("rst_serial_pronto", {31'd0, serial_pronto}, 32'd0);
    check("rst_sensor_pronto", {31'd0, sensor_pronto}, 32'd0);
    check("rst_tick", {31'd0, tick_2s}, 32'd0);

    // Distance starts at 000; then a request made mid-frame must be dropped.
    send(4, 0, 1'b0);
    send(1, 1, 1'b1);
    send(3, 5, 1'b0);

    widths = '{250, 9, 10, 1, 9990, 10000};
    for (int i = 0; i < 3; i++) widths.push_back(int'($urandom_range(11, 1500)));
    foreach (widths[i]) measure(widths[i]);

    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);

    // PWM: change the position just after each rise; it must apply from the next period.
    prev = 0;
    t0 = 0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      wait_rise(ok, t1);
      check("pwm_rise", {31'd0, ok}, 32'd1);
      if (i > 0) check("pwm_period", t1 - t0, PER);
      t0 = t1;
      nxt = (i == 0) ? 7 : int'($urandom_range(0, 7));
      sel_posicao = 3'(nxt);
      w = 0;
      while (pwm && w < 2 * PER) begin @(negedge clock); w++; end
      check("pwm_width", w, PMIN + prev * PSTP);
      prev = nxt;
    end

    // Tick timer: clear beats count, then bursts of enables with holds in between.
    @(posedge clock); #1;
    limpa_tick_2s = 1'b1; conta_tick_2s = 1'b1;
    @(posedge clock); #1;
    limpa_tick_2s = 1'b0; conta_tick_2s = 1'b0;
    check("tick_clr_prio", {28'd0, contador}, 32'd0);
    base = tick_seen;
    enable_cycles(40);
    repeat (3) @(posedge clock); #1;
    check("tick_count40", tick_seen - base, 5);
    check("contador40", {28'd0, contador}, 32'd5);
    enable_cycles(5);
    limpa_tick_2s = 1'b1;
    @(posedge clock); #1;
    limpa_tick_2s = 1'b0;
    check("contador_clr", {28'd0, contador}, 32'd0);
    base = tick_seen;
    left = 132;
    while (left > 0) begin
      burst = int'($urandom_range(1, 20));
      if (burst > left) burst = left;
      enable_cycles(burst);
      left -= burst;
      repeat ($urandom_range(0, 5)) @(posedge clock);
      #1;
    end
    repeat (3) @(posedge clock); #1;
    check("tick_count132", tick_seen - base, 132 / TICK);
    check("contador132", {28'd0, contador}, 32'((132 / TICK) % 16));
    enable_cycles(8);
    repeat (3) @(posedge clock); #1;
    check("tick_count17", tick_seen - base, 17);
    check("contador17", {28'd0, contador}, 32'd1);

    repeat (10) @(posedge clock); #1;
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
